// File: rtl/gnr_sim_ctrl.sv
// Sequences a boolean-network node array: load, settle, step/check loop, streams {s1,s0} snapshots.
// Stops on a fixed point (two consecutive unchanged checks), the step limit, or abort.
module gnr_sim_ctrl #(
    parameter int NODES = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NODES-1:0]   init_vec,
    input  logic [CNT_W-1:0]   max_steps,
    output logic               reset_nos,
    output logic [NODES-1:0]   init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [NODES-1:0]   node_s0,
    input  logic [NODES-1:0]   node_s1,
    output logic               snap_valid,
    input  logic               snap_ready,
    output logic [2*NODES-1:0] snap_data,
    output logic [CNT_W-1:0]   snap_step,
    output logic               busy,
    output logic               done,
    output logic               fixed_point,
    output logic [CNT_W-1:0]   steps
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_STEP, S_CHECK, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NODES-1:0]   init_q, init_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic               fixed_q, fixed_d;
    logic [1:0]         stable_q, stable_d;
    logic [2*NODES-1:0] prev_q, prev_d;
    logic               snap_vld_q, snap_vld_d;
    logic [2*NODES-1:0] snap_dat_q, snap_dat_d;
    logic [CNT_W-1:0]   snap_step_q, snap_step_d;
    logic               reset_nos_q, reset_nos_d;
    logic               strobe_q, strobe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*NODES-1:0] live;

    assign live = {node_s1, node_s0};

    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        max_d       = max_q;
        steps_d     = steps_q;
        fixed_d     = fixed_q;
        stable_d    = stable_q;
        prev_d      = prev_q;
        snap_vld_d  = snap_vld_q;
        snap_dat_d  = snap_dat_q;
        snap_step_d = snap_step_q;

        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            snap_vld_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        init_d   = init_vec;
                        max_d    = max_steps;
                        steps_d  = '0;
                        fixed_d  = 1'b0;
                        stable_d = 2'd0;
                        state_d  = S_LOAD;
                    end
                end
                S_LOAD: state_d = S_SETTLE;
                S_SETTLE: begin
                    prev_d  = live;
                    state_d = (max_q == '0) ? S_DONE : S_STEP;
                end
                S_STEP: begin
                    steps_d = steps_q + CNT_W'(1);
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    // First CHECK cycle (valid still low) samples the post-step node vectors.
                    if (!snap_vld_q) begin
                        snap_vld_d  = 1'b1;
                        snap_dat_d  = live;
                        snap_step_d = steps_q;
                        prev_d      = live;
                        if (live == prev_q)
                            stable_d = (stable_q == 2'd2) ? 2'd2 : stable_q + 2'd1;
                        else
                            stable_d = 2'd0;
                    end else if (snap_ready) begin
                        snap_vld_d = 1'b0;
                        if (stable_q == 2'd2) begin
                            fixed_d = 1'b1;
                            state_d = S_DONE;
                        end else if (steps_q == max_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        reset_nos_d = (state_d == S_LOAD);
        strobe_d    = (state_d == S_STEP);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            init_q      <= '0;
            max_q       <= '0;
            steps_q     <= '0;
            fixed_q     <= 1'b0;
            stable_q    <= 2'd0;
            prev_q      <= '0;
            snap_vld_q  <= 1'b0;
            snap_dat_q  <= '0;
            snap_step_q <= '0;
            reset_nos_q <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            max_q       <= max_d;
            steps_q     <= steps_d;
            fixed_q     <= fixed_d;
            stable_q    <= stable_d;
            prev_q      <= prev_d;
            snap_vld_q  <= snap_vld_d;
            snap_dat_q  <= snap_dat_d;
            snap_step_q <= snap_step_d;
            reset_nos_q <= reset_nos_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign reset_nos   = reset_nos_q;
    assign init_state  = init_q;
    assign start_s0    = strobe_q;
    assign start_s1    = strobe_q;
    assign snap_valid  = snap_vld_q;
    assign snap_data   = snap_dat_q;
    assign snap_step   = snap_step_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fixed_point = fixed_q;
    assign steps       = steps_q;

endmodule

// File: tb/tb_gnr_sim_ctrl.sv
// Bench for gnr_sim_ctrl with a 2-node array model (identity or toggling s1).
module tb_gnr_sim_ctrl;

    localparam int NODES = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, start, abort, snap_ready;
    logic [NODES-1:0] init_vec;
    logic [CNT_W-1:0] max_steps;
    logic             reset_nos, start_s0, start_s1, snap_valid, busy, done, fixed_point;
    logic [NODES-1:0] init_state, node_s0, node_s1;
    logic [3:0]       snap_data;
    logic [CNT_W-1:0] snap_step, steps;

    int n_checks = 0;
    int n_fail   = 0;
    logic toggle_mode = 1'b0;

    always #5 clk = ~clk;

    gnr_sim_ctrl #(.NODES(NODES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .init_vec(init_vec), .max_steps(max_steps),
        .reset_nos(reset_nos), .init_state(init_state),
        .start_s0(start_s0), .start_s1(start_s1),
        .node_s0(node_s0), .node_s1(node_s1),
        .snap_valid(snap_valid), .snap_ready(snap_ready),
        .snap_data(snap_data), .snap_step(snap_step),
        .busy(busy), .done(done), .fixed_point(fixed_point), .steps(steps)
    );

    // Node array model: load on reset_nos, s0 holds, s1 holds or inverts on start_s1.
    always @(posedge clk) begin
        if (rst) begin
            node_s0 <= '0;
            node_s1 <= '0;
        end else if (reset_nos) begin
            node_s0 <= init_state;
            node_s1 <= init_state;
        end else if (start_s1 && toggle_mode) begin
            node_s1 <= ~node_s1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       st, ab, rdy;
        logic [1:0] init;
        logic [7:0] mx;
        logic       rn, stb, sv;
        logic [3:0] dat;
        logic [7:0] ss;
        logic       bsy, dn, fp;
        logic [7:0] stp;
    } vec_t;

    function automatic vec_t mk(input logic st, ab, rdy, input logic [1:0] init, input logic [7:0] mx,
                                input logic rn, stb, sv, input logic [3:0] dat, input logic [7:0] ss,
                                input logic bsy, dn, fp, input logic [7:0] stp);
        vec_t v;
        v.st = st; v.ab = ab; v.rdy = rdy; v.init = init; v.mx = mx;
        v.rn = rn; v.stb = stb; v.sv = sv; v.dat = dat; v.ss = ss;
        v.bsy = bsy; v.dn = dn; v.fp = fp; v.stp = stp;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        int last_strobe, nsnap, k;
        logic [3:0] exp_dat;

        // Identity nodes, init 01, limit 10: fixed point after step 2.
        vecs[0]  = mk(1,0,1,2'b01,8'd10, 1,0,0,4'h0,8'd0, 1,0,0,8'd0);
        vecs[1]  = mk(0,0,1,2'b01,8'd10, 0,0,0,4'h0,8'd0, 1,0,0,8'd0);
        vecs[2]  = mk(0,0,1,2'b01,8'd10, 0,1,0,4'h0,8'd0, 1,0,0,8'd0);
        vecs[3]  = mk(0,0,1,2'b01,8'd10, 0,0,0,4'h0,8'd0, 1,0,0,8'd1);
        vecs[4]  = mk(0,0,1,2'b01,8'd10, 0,0,1,4'h5,8'd1, 1,0,0,8'd1);
        vecs[5]  = mk(0,0,1,2'b01,8'd10, 0,1,0,4'h5,8'd1, 1,0,0,8'd1);
        vecs[6]  = mk(0,0,1,2'b01,8'd10, 0,0,0,4'h5,8'd1, 1,0,0,8'd2);
        vecs[7]  = mk(0,0,1,2'b01,8'd10, 0,0,1,4'h5,8'd2, 1,0,0,8'd2);
        vecs[8]  = mk(0,0,1,2'b01,8'd10, 0,0,0,4'h5,8'd2, 0,1,1,8'd2);
        vecs[9]  = mk(0,0,1,2'b01,8'd10, 0,0,0,4'h5,8'd2, 0,1,1,8'd2);
        // Restart from DONE with limit 0: LOAD, SETTLE, DONE, no steps.
        vecs[10] = mk(1,0,1,2'b10,8'd0,  1,0,0,4'h5,8'd2, 1,0,0,8'd0);
        vecs[11] = mk(0,0,1,2'b10,8'd0,  0,0,0,4'h5,8'd2, 1,0,0,8'd0);
        vecs[12] = mk(0,0,1,2'b10,8'd0,  0,0,0,4'h5,8'd2, 0,1,0,8'd0);
        vecs[13] = mk(0,0,1,2'b10,8'd0,  0,0,0,4'h5,8'd2, 0,1,0,8'd0);

        rst = 1'b1; start = 1'b0; abort = 1'b0; snap_ready = 1'b0;
        init_vec = '0; max_steps = '0;
        tick(); tick();
        check("rst_reset_nos", reset_nos, 0);
        check("rst_init_state", init_state, 0);
        check("rst_strobes", {start_s0, start_s1}, 0);
        check("rst_snap_valid", snap_valid, 0);
        check("rst_snap_data", snap_data, 0);
        check("rst_snap_step", snap_step, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_fixed_point", fixed_point, 0);
        check("rst_steps", steps, 0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            start = vecs[i].st; abort = vecs[i].ab; snap_ready = vecs[i].rdy;
            init_vec = vecs[i].init; max_steps = vecs[i].mx;
            tick();
            check($sformatf("v%0d_reset_nos", i), reset_nos, vecs[i].rn);
            check($sformatf("v%0d_start_s0", i), start_s0, vecs[i].stb);
            check($sformatf("v%0d_start_s1", i), start_s1, vecs[i].stb);
            check($sformatf("v%0d_snap_valid", i), snap_valid, vecs[i].sv);
            check($sformatf("v%0d_snap_data", i), snap_data, vecs[i].dat);
            check($sformatf("v%0d_snap_step", i), snap_step, vecs[i].ss);
            check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
            check($sformatf("v%0d_done", i), done, vecs[i].dn);
            check($sformatf("v%0d_fixed_point", i), fixed_point, vecs[i].fp);
            check($sformatf("v%0d_steps", i), steps, vecs[i].stp);
            check($sformatf("v%0d_init_state", i), init_state, vecs[i].init);
        end
        start = 1'b0;

        // Toggling s1, limit 5: five snapshots, strobes every 3 cycles, no fixed point.
        toggle_mode = 1'b1; init_vec = 2'b01; max_steps = 8'd5; snap_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        last_strobe = -1; nsnap = 0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            tick();
            if (start_s0) begin
                check("tog_s1_with_s0", start_s1, 1);
                if (last_strobe >= 0) check("tog_spacing", cyc - last_strobe, 3);
                last_strobe = cyc;
            end
            if (snap_valid) begin
                nsnap++;
                exp_dat = (nsnap % 2 == 1) ? 4'b1001 : 4'b0101;
                check($sformatf("tog_snap%0d_data", nsnap), snap_data, exp_dat);
                check($sformatf("tog_snap%0d_step", nsnap), snap_step, nsnap);
            end
            if (done) break;
        end
        check("tog_done", done, 1);
        check("tog_fixed_point", fixed_point, 0);
        check("tog_steps", steps, 5);
        check("tog_nsnap", nsnap, 5);

        // Backpressure: valid and data hold, no strobes; a start while busy is ignored.
        init_vec = 2'b00; max_steps = 8'd3; snap_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !snap_valid; cyc++) tick();
        check("bp_first_valid", snap_valid, 1);
        check("bp_first_data", snap_data, 4'b1100);
        check("bp_first_step", snap_step, 1);
        for (int h = 0; h < 4; h++) begin
            start = (h == 0);
            tick();
            check("bp_hold_valid", snap_valid, 1);
            check("bp_hold_data", snap_data, 4'b1100);
            check("bp_no_strobe", start_s0, 0);
        end
        start = 1'b0;
        check("bp_busy", busy, 1);
        check("bp_steps", steps, 1);
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        check("bp_accept_valid", snap_valid, 0);
        check("bp_accept_strobe", start_s0, 1);
        for (int cyc = 0; cyc < 20 && !snap_valid; cyc++) tick();
        check("bp_second_step", snap_step, 2);

        // Abort in CHECK with valid high beats start and ready.
        abort = 1'b1; start = 1'b1; snap_ready = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", snap_valid, 0);
        check("abort_done", done, 0);
        check("abort_strobe", start_s0, 0);
        check("abort_steps", steps, 2);
        tick();
        check("abort_idle_busy", busy, 0);
        check("abort_idle_reset_nos", reset_nos, 0);

        // Fresh run from IDLE: identity, limit 1 ends on the limit, not a fixed point.
        toggle_mode = 1'b0; init_vec = 2'b11; max_steps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("new_busy", busy, 1);
        k = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (snap_valid) begin
                k++;
                check("new_snap_data", snap_data, 4'b1111);
            end
            if (done) break;
        end
        check("new_done", done, 1);
        check("new_fixed_point", fixed_point, 0);
        check("new_steps", steps, 1);
        check("new_nsnap", k, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
